// File: rtl/proc_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction width, pc step.
package proc_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH_WAIT = 2'd0,
    HOLD       = 2'd1,
    DONE       = 2'd2
  } fetch_state_e;

  // Word-align an address; the fetch pc never carries byte offsets.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_lat_counter.sv
// Read-latency down-counter: reloads to RD_LAT-1, counts down to zero and holds.
module fetch_lat_counter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [3:0] LOAD_VAL = 4'(RD_LAT - 1);

  logic [3:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= LOAD_VAL;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (dec && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Single-outstanding instruction fetch controller with redirect and program end.
// Optional FETCH_INSTR_COUNT_EN adds an instr_count output of accepted instructions.
module instr_fetch_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned RD_LAT   = 2,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] END_ADDR = 32'd20
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redir_valid,
  input  logic [31:0]        redir_pc,
  output logic               done
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [31:0]        instr_count
`endif
);

  fetch_state_e       state_reg, state_next;
  logic [31:0]        pc_reg, pc_next, pc_inc;
  logic [INSTR_W-1:0] instr_reg;
  logic [31:0]        instr_pc_reg;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic               capture, handshake;

  fetch_lat_counter #(
    .RD_LAT(RD_LAT)
  ) u_lat (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  assign pc_inc    = pc_reg + PC_INC;
  assign handshake = (state_reg == HOLD) && instr_ready;
  assign cnt_dec   = (state_reg == FETCH_WAIT) && !redir_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FETCH_WAIT;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (capture) begin
        instr_reg    <= imem_instr;
        instr_pc_reg <= pc_reg;
      end
    end
  end

  // A redirect overrides everything, including a handshake in the same cycle.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_load   = 1'b0;
    capture    = 1'b0;
    if (redir_valid) begin
      pc_next    = align_pc(redir_pc);
      state_next = FETCH_WAIT;
      cnt_load   = 1'b1;
    end else begin
      case (state_reg)
        FETCH_WAIT: begin
          if (pc_reg >= END_ADDR) begin
            state_next = DONE;
          end else if (cnt_zero) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc_next    = pc_inc;
            cnt_load   = 1'b1;
            state_next = (pc_inc >= END_ADDR) ? DONE : FETCH_WAIT;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    imem_addr   = pc_reg;
    instr       = instr_reg;
    instr_pc    = instr_pc_reg;
    instr_valid = (state_reg == HOLD);
    done        = (state_reg == DONE);
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (handshake) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign instr_count = count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed scenarios then randomized traffic.
module tb_instr_fetch_ctrl;

  localparam int unsigned RD_LAT   = 2;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] END_ADDR = 32'd20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'd0;
  logic        done;
`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .RD_LAT  (RD_LAT),
    .RESET_PC(RESET_PC),
    .END_ADDR(END_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .done       (done)
`ifdef FETCH_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory returns the real word only once the address has been stable RD_LAT-1 edges.
  logic [31:0] mem_addr_q = 32'hFFFF_FFFF;
  int          mem_age = 0;
  int          age_now;
  always_comb begin
    age_now    = (imem_addr != mem_addr_q) ? 0 : mem_age;
    imem_instr = (age_now >= int'(RD_LAT) - 1) ? mem_word(imem_addr) : (32'hBAD0_0000 ^ imem_addr);
  end
  always @(posedge clk) begin
    mem_addr_q <= imem_addr;
    mem_age    <= (imem_addr != mem_addr_q) ? 1 : ((mem_age < 1000) ? mem_age + 1 : mem_age);
  end

  typedef struct {
    bit          valid;
    bit          done;
    bit          chk_addr;
    logic [31:0] pc;
    logic [31:0] word;
  } cyc_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } txn_t;

  cyc_exp_t cyc_q[$];
  txn_t     hs_q[$];

  // Reference model: a fetch begun in cycle s is presented from cycle s+RD_LAT until taken.
  logic [31:0] m_pc = RESET_PC;
  int          m_start = 0;
  bit          m_done = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_count = 32'd0;
  bit          p_redir = 1'b0;
  bit          p_reset = 1'b1;
  bit          p_hs = 1'b0;
  logic [31:0] p_rpc = 32'd0;
  int          c = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, c);
    end
  endtask

  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rp, input bit rs);
    cyc_exp_t e;
    txn_t     t;
    @(posedge clk);
    #1;
    c++;
    if (!p_reset) begin
      if (p_redir) begin
        m_pc    = p_rpc & ~32'd3;
        m_start = c;
        m_done  = 1'b0;
      end else if (m_done) begin
        m_done = 1'b1;
      end else if (m_pc >= END_ADDR) begin
        m_done = 1'b1;
      end else if (p_hs) begin
        m_pc = m_pc + 32'd4;
        if (m_pc >= END_ADDR) m_done = 1'b1;
        else m_start = c;
      end
    end
    if (rs) begin
      m_pc    = RESET_PC;
      m_done  = 1'b0;
      m_start = c;
      m_count = 32'd0;
    end else if (p_reset) begin
      m_start = c;
    end
    reset       = rs;
    instr_ready = rdy;
    redir_valid = rv;
    redir_pc    = rp;
    m_valid = !rs && !m_done && (m_pc < END_ADDR) && (c - m_start >= int'(RD_LAT));
    if (m_valid && rdy) begin
      t.pc   = m_pc;
      t.word = mem_word(m_pc);
      hs_q.push_back(t);
      m_count = m_count + 32'd1;
    end
    e.valid    = m_valid;
    e.done     = m_done && !rs;
    e.chk_addr = !m_done || rs;
    e.pc       = m_pc;
    e.word     = mem_word(m_pc);
    cyc_q.push_back(e);
    p_redir = rv && !rs;
    p_rpc   = rp;
    p_reset = rs;
    p_hs    = m_valid && rdy;
  endtask

  task automatic chk_count();
`ifdef FETCH_INSTR_COUNT_EN
    chk("instr_count", instr_count, m_count - (p_hs ? 32'd1 : 32'd0));
`endif
  endtask

  // Monitor: per-cycle control checks plus transaction scoreboard on each handshake.
  always @(negedge clk) begin
    cyc_exp_t e;
    txn_t     t;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
      chk("done", {31'd0, done}, {31'd0, e.done});
      if (e.valid) begin
        chk("instr_pc_hold", instr_pc, e.pc);
        chk("instr_hold", instr, e.word);
      end
      if (e.chk_addr) chk("imem_addr", imem_addr, e.pc);
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (hs_q.size() == 0) begin
          chk("unexpected_handshake_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          t = hs_q.pop_front();
          $display("[TB] txn cycle %0d pc=%h instr=%h", c, instr_pc, instr);
          chk("txn_pc", instr_pc, t.pc);
          chk("txn_instr", instr, t.word);
        end
      end
    end
  end

  initial begin
    repeat (3) drive(0, 0, 32'd0, 1);

    // Straight run to program end with decode always ready.
    repeat (18) drive(1, 0, 32'd0, 0);
`ifdef FETCH_INSTR_COUNT_EN
    chk("instr_count_full_run", instr_count, 32'd5);
`endif
    chk_count();

    // Restart from DONE, then stall decode in HOLD.
    drive(0, 1, 32'd0, 0);
    repeat (RD_LAT + 6) drive(0, 0, 32'd0, 0);

    // Redirect to 0x0E while fetching pc 8.
    for (int i = 0; i < 40 && m_pc != 32'd8; i++) drive(1, 0, 32'd0, 0);
    drive(1, 1, 32'h0000_000E, 0);

    // Redirect coincident with the handshake of pc 12.
    for (int i = 0; i < 40 && !(m_pc == 32'd12 && m_valid); i++) drive(0, 0, 32'd0, 0);
    drive(1, 1, 32'h0000_0004, 0);
    repeat (20) drive(1, 0, 32'd0, 0);
    chk_count();
    drive(1, 1, 32'd0, 0);
    repeat (5) drive(1, 0, 32'd0, 0);

    // Redirects beyond the program end, including the top of the address space.
    drive(1, 1, 32'h0000_0040, 0);
    repeat (5) drive(1, 0, 32'd0, 0);
    drive(1, 1, 32'hFFFF_FFFE, 0);
    repeat (4) drive(1, 0, 32'd0, 0);

    // Reset pulse while holding pc 8.
    drive(1, 1, 32'd0, 0);
    for (int i = 0; i < 60 && !(m_pc == 32'd8 && m_valid); i++) drive(m_pc != 32'd8, 0, 32'd0, 0);
    drive(0, 0, 32'd0, 0);
    drive(0, 0, 32'd0, 1);
    repeat (10) drive(1, 0, 32'd0, 0);
    chk_count();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit          rdy, rv, rs;
      logic [31:0] rp;
      rs  = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 99) < 8);
      rp  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 99) < 70);
      drive(rdy, rv, rp, rs);
    end
    drive(0, 0, 32'd0, 0);
    repeat (20) drive(1, 0, 32'd0, 0);
    drive(0, 0, 32'd0, 0);
    chk_count();

    @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(hs_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
